// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: fixed-latency countdown, busy/done handshake and atomic HI/LO commit.
// Optional MD_CANCEL_EN adds a cancel input that aborts an in-flight operation or drops an E-stage command.
module md_sequencer #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MD_CANCEL_EN
    input  logic        cancel,
`endif
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    typedef enum logic { S_IDLE, S_RUN } state_e;
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               cancel_c;

`ifdef MD_CANCEL_EN
    assign cancel_c = cancel;
`else
    assign cancel_c = 1'b0;
`endif

    // Datapath from latched operands; op_q[1] selects divide, op_q[0] selects unsigned.
    logic        is_div_c, is_signed_c, a_neg_c, b_neg_c, div_zero_c;
    logic [63:0] ext_a_c, ext_b_c, prod_c;
    logic [31:0] abs_a_c, abs_b_c, den_c, q_mag_c, r_mag_c, quot_c, rem_c;

    always_comb begin
        is_div_c    = op_q[1];
        is_signed_c = ~op_q[0];
        ext_a_c     = is_signed_c ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        ext_b_c     = is_signed_c ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod_c      = ext_a_c * ext_b_c;
        a_neg_c     = is_signed_c & a_q[31];
        b_neg_c     = is_signed_c & b_q[31];
        abs_a_c     = a_neg_c ? (~a_q + 32'd1) : a_q;
        abs_b_c     = b_neg_c ? (~b_q + 32'd1) : b_q;
        div_zero_c  = (b_q == 32'd0);
        den_c       = div_zero_c ? 32'd1 : abs_b_c;
        q_mag_c     = abs_a_c / den_c;
        r_mag_c     = abs_a_c % den_c;
        quot_c      = (a_neg_c ^ b_neg_c) ? (~q_mag_c + 32'd1) : q_mag_c;
        rem_c       = a_neg_c ? (~r_mag_c + 32'd1) : r_mag_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && !cancel_c) begin
                    case (op_e'(op))
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            op_d    = op[1:0];
                            a_d     = src_a;
                            b_d     = src_b;
                            state_d = S_RUN;
                            cnt_d   = op[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
                        end
                        OP_MTHI: hi_d = src_a;
                        OP_MTLO: lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (cancel_c) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (!is_div_c) begin
                        hi_d = prod_c[63:32];
                        lo_d = prod_c[31:0];
                    end else if (!div_zero_c) begin
                        hi_d = rem_c;
                        lo_d = quot_c;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Randomized self-checking bench for md_sequencer against a transaction-level HI/LO model.
// Define MD_CANCEL_EN for both files to also exercise the cancel path.
module tb_md_sequencer;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk, reset, start, cancel;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int          total, bad;
    logic [31:0] m_hi, m_lo;

    md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef MD_CANCEL_EN
        .cancel(cancel),
`endif
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected HI/LO after a command completes, from the architectural definition.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        longint      ps;
        logic [63:0] pu;
        sa = a;
        sb = b;
        case (o)
            3'd0: begin
                ps = longint'(sa) * longint'(sb);
                pu = ps;
                m_hi = pu[63:32];
                m_lo = pu[31:0];
            end
            3'd1: begin
                pu = {32'd0, a} * {32'd0, b};
                m_hi = pu[63:32];
                m_lo = pu[31:0];
            end
            3'd2: begin
                if (b == 32'd0) begin
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000;
                    m_hi = 32'd0;
                end else begin
                    m_lo = sa / sb;
                    m_hi = sa % sb;
                end
            end
            3'd3: begin
                if (b != 32'd0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endfunction

    task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom);
        src_a = $urandom;
        src_b = $urandom;
    endtask

    // Long op; inj>0 raises a stray mthi/mtlo start in that busy cycle. Returns in the done cycle.
    task automatic long_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input int inj);
        int   n;
        int   want;
        logic seen_done;
        want = o[1] ? DC : MC;
        drive(o, a, b);
        chk("done_low_after_accept", done, 1'b0);
        model(o, a, b);
        n = 0;
        seen_done = 1'b0;
        while (busy && n < 200) begin
            n++;
            if (done) seen_done = 1'b1;
            start = (n == inj);
            op    = 3'(4 + $urandom_range(1));
            src_a = (n == inj) ? 32'hAA : $urandom;
            src_b = $urandom;
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_len", 64'(n), 64'(want));
        chk("done_during_busy", seen_done, 1'b0);
        chk("done_pulse", done, 1'b1);
        chk("hi_commit", hi, m_hi);
        chk("lo_commit", lo, m_lo);
    endtask

    task automatic short_op(input logic [2:0] o, input logic [31:0] a);
        drive(o, a, $urandom);
        model(o, a, 32'd0);
        chk("short_busy", busy, 1'b0);
        chk("short_done", done, 1'b0);
        chk("short_hi", hi, m_hi);
        chk("short_lo", lo, m_lo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          n;
        logic        seen;
        logic [2:0]  o;
        total  = 0;
        bad    = 0;
        m_hi   = 32'd0;
        m_lo   = 32'd0;
        reset  = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        op     = 3'd0;
        src_a  = 32'd0;
        src_b  = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        long_op(3'd0, 32'hFFFF_FFFE, 32'd3, 0);
        @(negedge clk);
        chk("done_single", done, 1'b0);
        long_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
        short_op(3'd4, 32'h1234_5678);
        short_op(3'd5, 32'h1234_5678);
        long_op(3'd3, 32'hDEAD_BEEF, 32'd0, 0);
        long_op(3'd0, 32'd4, 32'd5, 2);
        long_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        long_op(3'd0, 32'd3, 32'd3, 0);
        long_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);

        // Reset in the third busy cycle of a divide discards it.
        short_op(3'd4, 32'h55);
        drive(3'd2, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_hi", hi, 32'd0);
        chk("mid_rst_lo", lo, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("no_done_after_rst", seen, 1'b0);

`ifdef MD_CANCEL_EN
        short_op(3'd5, 32'h77);
        drive(3'd0, 32'd6, 32'd7);
        n = 1;
        while (n < int'(MC)) begin
            @(negedge clk);
            n++;
        end
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", busy, 1'b0);
        chk("cancel_done", done, 1'b0);
        chk("cancel_hi", hi, m_hi);
        chk("cancel_lo", lo, m_lo);
        cancel = 1'b1;
        drive(3'd4, 32'h99, 32'd0);
        cancel = 1'b0;
        chk("cancel_idle_hi", hi, m_hi);
        chk("cancel_idle_busy", busy, 1'b0);
`endif

        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(7));
            if (o < 3'd4) begin
                long_op(o, pick(), pick(), int'($urandom_range(0, 12)));
            end else if (o < 3'd6) begin
                short_op(o, $urandom);
            end else begin
                drive(o, $urandom, $urandom);
                chk("rsvd_busy", busy, 1'b0);
                chk("rsvd_hi", hi, m_hi);
                chk("rsvd_lo", lo, m_lo);
            end
            repeat ($urandom_range(1)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
